// File: rtl/key_pulse.sv
// Five-key push-button conditioner: two-flop synchroniser, per-key debounce FSM,
// single-cycle press pulse and optional auto-repeat while a key stays held.
module key_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_in_n,
  output logic [4:0] option_key,
  output logic [4:0] key_state
);

  localparam int unsigned NKEYS = 5;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_REL
  } state_t;

  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       pressed;
  logic [4:0]       fire;
  logic [4:0]       held_next;
  state_t           state      [NKEYS];
  state_t           state_next [NKEYS];
  logic [CNT_W-1:0] cnt        [NKEYS];
  logic [CNT_W-1:0] cnt_next   [NKEYS];

  // Synchroniser flops reset to released so a key held through reset re-debounces.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in_n;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      option_key <= '0;
      key_state  <= '0;
    end else begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      option_key <= fire;
      key_state  <= held_next;
    end
  end

  always_comb begin
    fire      = '0;
    held_next = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          cnt_next[i] = '0;
          if (pressed[i]) state_next[i] = DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!pressed[i]) begin
            state_next[i] = IDLE;
            cnt_next[i]   = '0;
          end else if (cnt[i] == DEB_LAST) begin
            state_next[i] = HELD;
            cnt_next[i]   = '0;
            fire[i]       = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!pressed[i]) begin
            state_next[i] = DEB_REL;
            cnt_next[i]   = '0;
          end else if (REPEAT_EN && cnt[i] == DELAY_LAST) begin
            state_next[i] = REPEAT;
            cnt_next[i]   = '0;
            fire[i]       = 1'b1;
          end else if (cnt[i] != DELAY_LAST) begin
            // Saturates when repeat is disabled so the counter never wraps.
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!pressed[i]) begin
            state_next[i] = DEB_REL;
            cnt_next[i]   = '0;
          end else if (cnt[i] == RATE_LAST) begin
            cnt_next[i] = '0;
            fire[i]     = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        DEB_REL: begin
          if (pressed[i]) begin
            state_next[i] = HELD;
            cnt_next[i]   = '0;
          end else if (cnt[i] == DEB_LAST) begin
            state_next[i] = IDLE;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_next[i] = IDLE;
          cnt_next[i]   = '0;
        end
      endcase
      held_next[i] = (state_next[i] == HELD) || (state_next[i] == REPEAT) ||
                     (state_next[i] == DEB_REL);
    end
  end

endmodule

// File: doc/key_pulse.md
# key_pulse

Front-end conditioner for the five duty-adjust push buttons that drive the PWM generator's `option_key[4:0]` input. It synchronises the raw active-low button lines to `clk` and debounces each one independently. It emits a single-cycle pulse per accepted press, plus auto-repeat pulses while a button stays held. This lets one press move the PWM duty by exactly one step, and a long hold ramps it.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a press or a release (20 ms at 50 MHz). Minimum 2.
- `REPEAT_DELAY`, default 25_000_000: cycles from the accepted press to the first repeat pulse (500 ms). Minimum 2.
- `REPEAT_RATE`, default 5_000_000: cycles between subsequent repeat pulses (100 ms). Minimum 2.
- `REPEAT_EN`, default 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.
- `CNT_W`, default 25: per-key counter width. It must hold the largest of the three cycle parameters minus 1.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `key_in_n`  in  5  raw button lines, asynchronous, 0 = pressed. Bit i maps to `option_key[i]`.
- `option_key`  out  5  one-cycle press/repeat pulses, registered. Connects directly to the PWM block.
- `key_state`  out  5  debounced level per key, registered, 1 = held.

## Operation
- Synchroniser: two flops per bit, reset to 1 (released). The internal `pressed[i]` is the inverse of the second flop.
- One FSM and one `CNT_W`-bit counter per key; all five keys are fully independent.
- IDLE: cnt = 0. If `pressed` -> DEB_PRESS with cnt = 0.
- DEB_PRESS: if not `pressed` -> IDLE. Else cnt++.
  - When cnt == DEBOUNCE_CYCLES-1 with `pressed`: go to HELD, cnt = 0, fire pulse.
- HELD: if not `pressed` -> DEB_REL with cnt = 0. Else cnt++.
  - If REPEAT_EN and cnt == REPEAT_DELAY-1: fire pulse, go to REPEAT, cnt = 0.
- REPEAT: if not `pressed` -> DEB_REL with cnt = 0. Else cnt++.
  - When cnt == REPEAT_RATE-1: fire pulse, cnt = 0, stay in REPEAT.
- DEB_REL: if `pressed` -> HELD with cnt = 0 (bounce during release; the repeat delay restarts, no pulse). Else cnt++.
  - When cnt == DEBOUNCE_CYCLES-1: go to IDLE.
- "Fire pulse": `option_key[i]` is 1 for exactly the one cycle following that clock edge, and 0 otherwise.
- `key_state[i]` = 1 while in HELD, REPEAT or DEB_REL. It is updated on the same edge as the state.
- Simultaneous presses: several `option_key` bits may be high in the same cycle. Resolving priority is the downstream block's job (bit 4 highest).
- Counters never wrap. Each one is cleared on every state change, and its maximum value is parameter-1.

## Timing
- Reset: all FSMs go to IDLE, counters to 0, `option_key` = 0, `key_state` = 0, synchroniser flops = 1.
- Reset asserted mid-operation: all of the above takes effect on the next edge with no pulse emitted. A key held through reset release is treated as a new press and produces a pulse after full debounce.
- Press latency: `key_in_n[i]` sampled 0 at edge k (and stable afterwards) -> FSM enters DEB_PRESS at edge k+2. `option_key[i]` is then high during the cycle after edge k+2+DEBOUNCE_CYCLES. `key_state[i]` rises at that same edge.
- Repeat: the first repeat pulse comes REPEAT_DELAY cycles after the press pulse. Later pulses are spaced exactly REPEAT_RATE cycles apart.
- Release: a stable release sampled at edge r -> `key_state[i]` falls at edge r+2+DEBOUNCE_CYCLES. No pulse on release.
- A bounce shorter than DEBOUNCE_CYCLES restarts the count and produces no pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3 unless stated otherwise.
- Clean press of key 2 sampled at edge 0, held 8 cycles -> exactly one pulse on `option_key[2]`, high after edge 6 for 1 cycle; `key_state[2]` = 1 from edge 6; no other bits toggle.
- Bouncy press on key 0 (low 2, high 1, low 2, high 1), then stable low -> no pulse during the bounce; one pulse 6 edges after the last 1->0 sample.
- Hold key 4 for 30 cycles -> pulses at edges 6, 16, 19, 22, 25, 28, 31 (the last only if still in REPEAT, since the release debounce has not yet completed). With REPEAT_EN=0 -> only the edge-6 pulse.
- Keys 1 and 3 pressed on the same edge -> `option_key` = 5'b01010 for one cycle at edge 6.
- Release bounce: while in HELD, key goes high 2 cycles then low again -> `key_state` stays 1, no pulse, and the next repeat comes 10 cycles after re-entering HELD.
- Assert `rst` for 1 cycle while key 2 is in REPEAT -> outputs 0 on the next edge. With the key still held, a new pulse arrives 6 edges after the first post-reset sample.
